// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with valid/ready intake and gap-free streaming
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    assign last       = (state == SHIFT) && (cnt == LAST);
    assign in_ready   = (state == IDLE) || last;
    assign accept     = in_valid && in_ready;
    assign sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sout_valid = busy;
    // frame sequencing: load on accept, shift each cycle, clear the line when the frame ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= in_data;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == SHIFT && !last) begin
            sreg  <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            cnt   <= cnt + 1'b1;
            done  <= (cnt == LAST - 1'b1);
        end else if (last) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: table, directed and random checks of piso_tx against a bit-queue reference model
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic       v2 = 1'b0;
    logic [1:0] d2 = 2'b00;
    logic [2:0] rdy, so, sv, bz, dn;
    bit         q0[$], q1[$], q2[$];
    int         checks = 0, errors = 0;
    logic       acc0, acc2;
    int         n;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s, svl, dne, rd;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0),
        .in_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0),
        .in_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
    piso_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2),
        .in_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // expected outputs follow from how many bits of the current frame are still on their way out
    task automatic chk_dut(input string nm, input int k, input int sz, input bit h);
        chk({nm, ".sout"}, so[k], (sz > 0) ? h : 1'b0);
        chk({nm, ".sout_valid"}, sv[k], sz > 0);
        chk({nm, ".busy"}, bz[k], sz > 0);
        chk({nm, ".done"}, dn[k], sz == 1);
        chk({nm, ".in_ready"}, rdy[k], sz <= 1);
    endtask

    task automatic chk_reset(input string nm);
        for (int k = 0; k < 3; k++) begin
            chk({nm, ".sout"}, so[k], 1'b0);
            chk({nm, ".sout_valid"}, sv[k], 1'b0);
            chk({nm, ".busy"}, bz[k], 1'b0);
            chk({nm, ".done"}, dn[k], 1'b0);
            chk({nm, ".in_ready"}, rdy[k], 1'b1);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk_dut("u0", 0, q0.size(), (q0.size() > 0) ? q0[0] : 1'b0);
        chk_dut("u1", 1, q1.size(), (q1.size() > 0) ? q1[0] : 1'b0);
        chk_dut("u2", 2, q2.size(), (q2.size() > 0) ? q2[0] : 1'b0);
    endtask

    // one clock of the reference: the shown bit leaves, an accepted word appends all its bits in send order
    task automatic advance();
        acc0 = v0 && (q0.size() <= 1);
        acc2 = v2 && (q2.size() <= 1);
        @(posedge clk);
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        if (q2.size() > 0) void'(q2.pop_front());
        if (acc0)
            for (int i = 0; i < 8; i++) begin
                q0.push_back(d0[7-i]);
                q1.push_back(d0[i]);
            end
        if (acc2)
            for (int i = 0; i < 2; i++) q2.push_back(d2[1-i]);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic send(input logic [7:0] d, output int cyc);
        v0 = 1'b1;
        d0 = d;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!acc0 && cyc < 40);
        chk("send_accept", acc0, 1'b1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        #1;
        chk_reset("reset");
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single 8'hB3 frame, MSB-first on u0 and LSB-first on u1 in parallel
        for (int i = 0; i < 10; i++) begin
            v0 = tbl[i].v;
            d0 = tbl[i].d;
            sample();
            chk($sformatf("tbl%0d.sout", i), so[0], tbl[i].s);
            chk($sformatf("tbl%0d.sout_valid", i), sv[0], tbl[i].svl);
            chk($sformatf("tbl%0d.done", i), dn[0], tbl[i].dne);
            chk($sformatf("tbl%0d.in_ready", i), rdy[0], tbl[i].rd);
            advance();
        end

        // back-to-back A5 then 3C with in_valid held
        send(8'hA5, n);
        send(8'h3C, n);
        chk("b2b_accept_gap", n, 8);
        v0 = 1'b0;
        repeat (10) step();

        // FF requested during bit 3 of 00 waits for the last-bit cycle
        send(8'h00, n);
        v0 = 1'b0;
        repeat (3) step();
        send(8'hFF, n);
        chk("holdoff_cycles", n, 5);
        v0 = 1'b0;
        repeat (10) step();

        // asynchronous reset in the middle of a frame
        send(8'hB3, n);
        v0 = 1'b0;
        repeat (4) step();
        chk("pre_reset_valid", sv[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        q0.delete();
        q1.delete();
        q2.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h5A, n);
        v0 = 1'b0;
        repeat (10) step();

        // WIDTH=2 alternating words with in_valid held
        v2 = 1'b1;
        d2 = 2'b10;
        repeat (12) begin
            step();
            if (acc2) d2 = ~d2;
        end
        v2 = 1'b0;
        repeat (3) step();

        // random traffic on all instances
        repeat (1500) begin
            v0 = ($urandom_range(3) != 0);
            d0 = 8'($urandom);
            v2 = 1'($urandom_range(1));
            d2 = 2'($urandom);
            step();
        end
        v0 = 1'b0;
        v2 = 1'b0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
